// File: rtl/fetch_pipeline_unit.sv
// Fetch stage: owns the byte PC, drives a 1-cycle-latency instruction RAM and
// presents one instruction per cycle, squashing wrong-path slots on redirect.
module fetch_pipeline_unit #(
  parameter int unsigned PC_WIDTH = 11,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'hE320_F000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sel_stall,
  input  logic                sel_redirect,
  input  logic [31:0]         redirect_pc,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [31:0]         imem_rdata,
  output logic [31:0]         instr_out,
  output logic                branch_out,
  output logic [31:0]         pc_out
);

  logic [31:0] pc_reg;
  logic [31:0] pc_d1;
  logic        valid_d1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg   <= RESET_PC;
      pc_d1    <= RESET_PC;
      valid_d1 <= 1'b0;
    end else if (sel_redirect) begin
      // pc_d1 is held so pc_out stays put through the two squashed slots
      pc_reg   <= {redirect_pc[31:2], 2'b00};
      valid_d1 <= 1'b0;
    end else if (!sel_stall) begin
      pc_d1    <= pc_reg;
      pc_reg   <= pc_reg + 32'd4;
      valid_d1 <= 1'b1;
    end
  end

  // While stalled the RAM re-reads the presented word so instr_out stays stable
  assign imem_addr  = sel_stall ? pc_d1[PC_WIDTH+1:2] : pc_reg[PC_WIDTH+1:2];
  assign instr_out  = (valid_d1 && !sel_redirect) ? imem_rdata : NOP;
  assign branch_out = (instr_out[27:25] == 3'b101) && (instr_out[31:28] != 4'b1111);
  assign pc_out     = pc_d1;

  logic unused_redirect_bits;
  assign unused_redirect_bits = ^redirect_pc[1:0];

endmodule

// File: tb/tb_fetch_pipeline_unit.sv
// Bench for fetch_pipeline_unit: per-cycle vector table on the default build,
// plus a free-running stream on a PC_WIDTH=4 build to exercise address wrap.
module tb_fetch_pipeline_unit;

  localparam logic [31:0] NOP = 32'hE320_F000;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        e_br;
    logic [31:0] e_addr;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        br;
    logic [31:0] addr;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        sel_stall;
  logic        sel_redirect;
  logic [31:0] redirect_pc;
  logic [10:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic        branch_out;
  logic [31:0] pc_out;

  logic        rst4_n;
  logic [3:0]  imem_addr4;
  logic [31:0] imem_rdata4;
  logic [31:0] instr_out4;
  logic        branch_out4;
  logic [31:0] pc_out4;

  logic [31:0] mem  [2048];
  logic [31:0] mem4 [16];

  vec_t vecs[$];
  exp_t exp_q[$];
  int   total;
  int   bad;

  fetch_pipeline_unit u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sel_stall    (sel_stall),
    .sel_redirect (sel_redirect),
    .redirect_pc  (redirect_pc),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .instr_out    (instr_out),
    .branch_out   (branch_out),
    .pc_out       (pc_out)
  );

  fetch_pipeline_unit #(.PC_WIDTH(4)) u_dut4 (
    .clk          (clk),
    .rst_n        (rst4_n),
    .sel_stall    (1'b0),
    .sel_redirect (1'b0),
    .redirect_pc  (32'h0),
    .imem_addr    (imem_addr4),
    .imem_rdata   (imem_rdata4),
    .instr_out    (instr_out4),
    .branch_out   (branch_out4),
    .pc_out       (pc_out4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    imem_rdata  <= mem[imem_addr];
    imem_rdata4 <= mem4[imem_addr4];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  task automatic add(input logic rst, input logic stall, input logic redir, input logic [31:0] rpc,
                     input logic [31:0] e_instr, input logic [31:0] e_pc, input logic e_br,
                     input logic [31:0] e_addr);
    vec_t v;
    v.rst = rst; v.stall = stall; v.redir = redir; v.rpc = rpc;
    v.e_instr = e_instr; v.e_pc = e_pc; v.e_br = e_br; v.e_addr = e_addr;
    vecs.push_back(v);
  endtask

  function automatic logic [31:0] w(input int k);
    return 32'hE280_0000 + k;
  endfunction

  initial begin
    exp_t e;
    vec_t v;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    rst4_n = 1'b0;
    sel_stall = 1'b0;
    sel_redirect = 1'b0;
    redirect_pc = 32'h0;

    for (int k = 0; k < 2048; k++) mem[k] = w(k);
    mem[3]   = 32'hEA00_0010;
    mem[17]  = 32'hEB00_0005;
    mem[65]  = 32'hFA00_0010;
    mem[193] = 32'h0A00_0001;
    for (int k = 0; k < 16; k++) mem4[k] = 32'hE1A0_0000 + k;

    //  rst st rd rpc            instr          pc            br addr
    add(0, 0, 0, 32'h0,          NOP,           32'h0,        0, 0);
    add(1, 0, 0, 32'h0,          NOP,           32'h0,        0, 0);
    add(1, 0, 0, 32'h0,          w(0),          32'h0,        0, 1);
    add(1, 0, 0, 32'h0,          w(1),          32'h4,        0, 2);
    add(1, 1, 0, 32'h0,          w(2),          32'h8,        0, 2);
    add(1, 1, 0, 32'h0,          w(2),          32'h8,        0, 2);
    add(1, 1, 0, 32'h0,          w(2),          32'h8,        0, 2);
    add(1, 0, 0, 32'h0,          w(2),          32'h8,        0, 3);
    add(1, 0, 0, 32'h0,          32'hEA00_0010, 32'hC,        1, 4);
    add(1, 0, 1, 32'h102,        NOP,           32'h10,       0, 5);
    add(1, 0, 0, 32'h0,          NOP,           32'h10,       0, 64);
    add(1, 0, 0, 32'h0,          w(64),         32'h100,      0, 65);
    add(1, 0, 0, 32'h0,          32'hFA00_0010, 32'h104,      0, 66);
    add(1, 1, 1, 32'h40,         NOP,           32'h108,      0, 66);
    add(1, 0, 0, 32'h0,          NOP,           32'h108,      0, 16);
    add(1, 0, 0, 32'h0,          w(16),         32'h40,       0, 17);
    add(1, 0, 0, 32'h0,          32'hEB00_0005, 32'h44,       1, 18);
    add(1, 0, 1, 32'h200,        NOP,           32'h48,       0, 19);
    add(1, 1, 0, 32'h0,          NOP,           32'h48,       0, 18);
    add(1, 1, 0, 32'h0,          NOP,           32'h48,       0, 18);
    add(1, 0, 0, 32'h0,          NOP,           32'h48,       0, 128);
    add(1, 0, 0, 32'h0,          w(128),        32'h200,      0, 129);
    add(1, 0, 1, 32'h300,        NOP,           32'h204,      0, 130);
    add(1, 0, 1, 32'h304,        NOP,           32'h204,      0, 192);
    add(1, 0, 0, 32'h0,          NOP,           32'h204,      0, 193);
    add(1, 0, 0, 32'h0,          32'h0A00_0001, 32'h304,      1, 194);
    add(1, 0, 1, 32'h30C,        NOP,           32'h308,      0, 195);
    add(1, 0, 0, 32'h0,          NOP,           32'h308,      0, 195);
    add(1, 0, 0, 32'h0,          w(195),        32'h30C,      0, 196);
    add(1, 0, 1, 32'hFFFF_FFFC,  NOP,           32'h310,      0, 197);
    add(1, 0, 0, 32'h0,          NOP,           32'h310,      0, 2047);
    add(1, 0, 0, 32'h0,          w(2047),       32'hFFFF_FFFC, 0, 0);
    add(1, 0, 0, 32'h0,          w(0),          32'h0,        0, 1);
    add(1, 0, 0, 32'h0,          w(1),          32'h4,        0, 2);
    add(0, 0, 0, 32'h0,          NOP,           32'h0,        0, 0);
    add(1, 0, 0, 32'h0,          NOP,           32'h0,        0, 0);
    add(1, 0, 0, 32'h0,          w(0),          32'h0,        0, 1);

    repeat (2) @(negedge clk);
    foreach (vecs[i]) begin
      v = vecs[i];
      rst_n = v.rst;
      sel_stall = v.stall;
      sel_redirect = v.redir;
      redirect_pc = v.rpc;
      exp_q.push_back('{instr: v.e_instr, pc: v.e_pc, br: v.e_br, addr: v.e_addr});
      #2;
      if (exp_q.size() == 0) begin
        chk($sformatf("v%0d_queue", i), 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("v%0d_instr", i), instr_out, e.instr);
        chk($sformatf("v%0d_pc", i), pc_out, e.pc);
        chk($sformatf("v%0d_branch", i), {31'd0, branch_out}, {31'd0, e.br});
        chk($sformatf("v%0d_addr", i), {21'd0, imem_addr}, e.addr);
      end
      @(negedge clk);
    end

    // PC_WIDTH=4 build: the RAM index wraps every 16 words while pc_out keeps counting
    rst4_n = 1'b1;
    for (int k = 0; k < 21; k++) begin
      if (k == 0)
        exp_q.push_back('{instr: NOP, pc: 32'h0, br: 1'b0, addr: 32'h0});
      else
        exp_q.push_back('{instr: 32'hE1A0_0000 + ((k - 1) % 16), pc: 32'(4 * (k - 1)),
                          br: 1'b0, addr: 32'(k % 16)});
      #2;
      e = exp_q.pop_front();
      chk($sformatf("w%0d_instr", k), instr_out4, e.instr);
      chk($sformatf("w%0d_pc", k), pc_out4, e.pc);
      chk($sformatf("w%0d_branch", k), {31'd0, branch_out4}, {31'd0, e.br});
      chk($sformatf("w%0d_addr", k), {28'd0, imem_addr4}, e.addr);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
